// File: rtl/top_pkg.sv
// Shared constants and state encoding for the image top-level sequencer.
package top_pkg;

  localparam int unsigned UART_TIMEOUT_DEFAULT  = 50000000;
  localparam logic [17:0] VGA_BASE_ADDR_DEFAULT = 18'd146944;
  localparam logic [17:0] WRITE_LIMIT_DEFAULT   = 18'd76799;
  localparam int unsigned TIMER_W               = 26;

  typedef enum logic [1:0] {
    S_IDLE           = 2'd0,
    S_ENABLE_UART_RX = 2'd1,
    S_WAIT_UART_RX   = 2'd2,
    S_M1             = 2'd3
  } top_state_e;

endpackage

// File: rtl/uart_rx_edge_sync.sv
// Two-flop synchronizer for the raw UART line plus a falling-edge detector.
module uart_rx_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/image_top_ctrl.sv
// Top sequencer and SRAM bus arbiter: VGA idle, UART load, then M1 decode.
// Optional out-of-range M1 write suppression via `define WRITE_GUARD_EN.
module image_top_ctrl
  import top_pkg::*;
#(
  parameter int unsigned UART_TIMEOUT  = UART_TIMEOUT_DEFAULT,
  parameter logic [17:0] VGA_BASE_ADDR = VGA_BASE_ADDR_DEFAULT,
  parameter logic [17:0] WRITE_LIMIT   = WRITE_LIMIT_DEFAULT
) (
  input  logic         Clock_50,
  input  logic         Reset,
  input  logic         UART_RX_I,
  output logic         UART_rx_enable_o,
  output logic         UART_unload_o,
  input  logic         UART_we_n_i,
  input  logic [17:0]  UART_address_i,
  input  logic [15:0]  UART_write_data_i,
  output logic         M1_start_o,
  input  logic         M1_done_i,
  input  logic         M1_we_n_i,
  input  logic [17:0]  M1_address_i,
  input  logic [15:0]  M1_write_data_i,
  input  logic [17:0]  VGA_address_i,
  output logic         VGA_enable_o,
  output logic [17:0]  SRAM_address_o,
  output logic [15:0]  SRAM_write_data_o,
  output logic         SRAM_we_n_o,
  output logic [17:0]  VGA_base_address,
  output logic [1:0]   top_state_o,
  output logic [25:0]  UART_timer_o,
  output logic         guard_error_o
);

  localparam logic [25:0] TMR_LAST = 26'(UART_TIMEOUT - 32'd1);

  top_state_e  state_q;
  logic [25:0] uart_timer_q;
  logic        rx_en_q;
  logic        unload_q;
  logic        start_q;
  logic        rx_fall;
  logic        guard_hit;
  logic        guard_error_q;

  uart_rx_edge_sync u_rx_sync (
    .clk_i  (Clock_50),
    .rst_i  (Reset),
    .rx_i   (UART_RX_I),
    .fall_o (rx_fall)
  );

  // >= rather than == so a timer pushed past the limit still times out.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      uart_timer_q <= '0;
      rx_en_q      <= 1'b0;
      unload_q     <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      rx_en_q  <= 1'b0;
      unload_q <= 1'b0;
      start_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_fall) begin
            state_q <= S_ENABLE_UART_RX;
            rx_en_q <= 1'b1;
          end
        end
        S_ENABLE_UART_RX: begin
          uart_timer_q <= '0;
          state_q      <= S_WAIT_UART_RX;
        end
        S_WAIT_UART_RX: begin
          if (uart_timer_q >= TMR_LAST) begin
            uart_timer_q <= '0;
            unload_q     <= 1'b1;
            start_q      <= 1'b1;
            state_q      <= S_M1;
          end else if (!UART_we_n_i) begin
            uart_timer_q <= '0;
          end else begin
            uart_timer_q <= uart_timer_q + 26'd1;
          end
        end
        S_M1: begin
          if (M1_done_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef WRITE_GUARD_EN
  assign guard_hit = (state_q == S_M1) && !M1_we_n_i
                   && (M1_address_i > WRITE_LIMIT);

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      guard_error_q <= 1'b0;
    end else if (guard_hit) begin
      guard_error_q <= 1'b1;
    end
  end
`else
  assign guard_hit     = 1'b0;
  assign guard_error_q = 1'b0;
`endif

  always_comb begin
    SRAM_address_o    = VGA_address_i;
    SRAM_write_data_o = '0;
    SRAM_we_n_o       = 1'b1;
    VGA_enable_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        VGA_enable_o = 1'b1;
      end
      S_ENABLE_UART_RX: begin
        SRAM_we_n_o = 1'b1;
      end
      S_WAIT_UART_RX: begin
        SRAM_address_o    = UART_address_i;
        SRAM_write_data_o = UART_write_data_i;
        SRAM_we_n_o       = UART_we_n_i;
      end
      S_M1: begin
        SRAM_address_o    = M1_address_i;
        SRAM_write_data_o = M1_write_data_i;
        SRAM_we_n_o       = M1_we_n_i | guard_hit;
      end
      default: begin
        SRAM_we_n_o = 1'b1;
      end
    endcase
  end

  assign UART_rx_enable_o = rx_en_q;
  assign UART_unload_o    = unload_q;
  assign M1_start_o       = start_q;
  assign VGA_base_address = VGA_BASE_ADDR;
  assign top_state_o      = state_q;
  assign UART_timer_o     = uart_timer_q;
  assign guard_error_o    = guard_error_q;

endmodule

// File: tb/tb_image_top_ctrl.sv
// Randomized self-checking bench for image_top_ctrl.
module tb_image_top_ctrl;
  import top_pkg::*;

`ifdef WRITE_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  logic        Clock_50 = 1'b0;
  logic        Reset;
  logic        UART_RX_I;
  logic        UART_rx_enable_o;
  logic        UART_unload_o;
  logic        UART_we_n_i;
  logic [17:0] UART_address_i;
  logic [15:0] UART_write_data_i;
  logic        M1_start_o;
  logic        M1_done_i;
  logic        M1_we_n_i;
  logic [17:0] M1_address_i;
  logic [15:0] M1_write_data_i;
  logic [17:0] VGA_address_i;
  logic        VGA_enable_o;
  logic [17:0] SRAM_address_o;
  logic [15:0] SRAM_write_data_o;
  logic        SRAM_we_n_o;
  logic [17:0] VGA_base_address;
  logic [1:0]  top_state_o;
  logic [25:0] UART_timer_o;
  logic        guard_error_o;

  int total = 0;
  int bad   = 0;
  int unsigned et;

  image_top_ctrl dut (
    .Clock_50          (Clock_50),
    .Reset             (Reset),
    .UART_RX_I         (UART_RX_I),
    .UART_rx_enable_o  (UART_rx_enable_o),
    .UART_unload_o     (UART_unload_o),
    .UART_we_n_i       (UART_we_n_i),
    .UART_address_i    (UART_address_i),
    .UART_write_data_i (UART_write_data_i),
    .M1_start_o        (M1_start_o),
    .M1_done_i         (M1_done_i),
    .M1_we_n_i         (M1_we_n_i),
    .M1_address_i      (M1_address_i),
    .M1_write_data_i   (M1_write_data_i),
    .VGA_address_i     (VGA_address_i),
    .VGA_enable_o      (VGA_enable_o),
    .SRAM_address_o    (SRAM_address_o),
    .SRAM_write_data_o (SRAM_write_data_o),
    .SRAM_we_n_o       (SRAM_we_n_o),
    .VGA_base_address  (VGA_base_address),
    .top_state_o       (top_state_o),
    .UART_timer_o      (UART_timer_o),
    .guard_error_o     (guard_error_o)
  );

  always #5 Clock_50 = ~Clock_50;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock_50);
    #1;
  endtask

  task automatic rand_bus();
    VGA_address_i     = 18'($urandom);
    UART_address_i    = 18'($urandom);
    UART_write_data_i = 16'($urandom);
    M1_address_i      = 18'($urandom_range(0, 76799));
    M1_write_data_i   = 16'($urandom);
    M1_we_n_i         = 1'($urandom);
  endtask

  // Expected bus contents from which engine owns SRAM in state st.
  task automatic chk_bus(input string tag, input int st);
    logic [17:0] a;
    logic [15:0] d;
    logic        w;
    a = VGA_address_i;
    d = '0;
    w = 1'b1;
    if (st == 2) begin
      a = UART_address_i;
      d = UART_write_data_i;
      w = UART_we_n_i;
    end else if (st == 3) begin
      a = M1_address_i;
      d = M1_write_data_i;
      w = M1_we_n_i;
      if (GUARD_ON && M1_address_i > WRITE_LIMIT_DEFAULT) w = 1'b1;
    end
    chk({tag, ".addr"}, SRAM_address_o, a);
    chk({tag, ".we_n"}, SRAM_we_n_o, w);
    chk({tag, ".vga_en"}, VGA_enable_o, st == 0);
    if (st >= 2) chk({tag, ".data"}, SRAM_write_data_o, d);
  endtask

  task automatic enter_uart(input string tag, output int unsigned exp_t);
    int          pulses = 0;
    int          nw = 0;
    int unsigned t0 = 99;
    bit          s1 = 1'b0;
    UART_we_n_i = 1'b1;
    UART_RX_I   = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) UART_RX_I = 1'b1;
      tick();
      if (UART_rx_enable_o) begin
        pulses++;
        chk({tag, ".en_state"}, top_state_o, 1);
      end
      if (top_state_o == 2'd1) s1 = 1'b1;
      if (top_state_o == 2'd2) begin
        if (nw == 0) t0 = UART_timer_o;
        nw++;
      end
    end
    chk({tag, ".en_pulses"}, pulses, 1);
    chk({tag, ".saw_s1"}, s1, 1);
    chk({tag, ".t_start"}, t0, 0);
    chk({tag, ".state"}, top_state_o, 2);
    chk({tag, ".t_run"}, UART_timer_o, nw - 1);
    exp_t = nw - 1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset       = 1'b1;
    UART_RX_I   = 1'b1;
    UART_we_n_i = 1'b1;
    M1_done_i   = 1'b0;
    rand_bus();
    repeat (3) tick();
    chk("rst.state", top_state_o, 0);
    chk("rst.we_n", SRAM_we_n_o, 1);
    chk("rst.vga_en", VGA_enable_o, 1);
    chk("rst.base", VGA_base_address, 146944);
    chk("rst.timer", UART_timer_o, 0);
    chk("rst.pulses", {UART_rx_enable_o, UART_unload_o, M1_start_o}, 0);
    chk("rst.guard", guard_error_o, 0);

    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_bus();
      #1 chk_bus("idle", 0);
      tick();
      chk("idle.state", top_state_o, 0);
    end

    enter_uart("rx1", et);

    for (int i = 0; i < 300; i++) begin
      rand_bus();
      UART_we_n_i = ($urandom_range(0, 7) != 0);
      #1 chk_bus("wait", 2);
      tick();
      et = UART_we_n_i ? et + 1 : 0;
      chk("wait.timer", UART_timer_o, et);
      chk("wait.state", top_state_o, 2);
    end

    UART_we_n_i = 1'b1;
    for (int i = 0; i < 2000 && UART_timer_o != 26'd1000; i++) tick();
    chk("w1000.timer", UART_timer_o, 1000);
    UART_we_n_i       = 1'b0;
    UART_address_i    = 18'd5;
    UART_write_data_i = 16'h1234;
    #1;
    chk("w1000.addr", SRAM_address_o, 5);
    chk("w1000.data", SRAM_write_data_o, 16'h1234);
    chk("w1000.we_n", SRAM_we_n_o, 0);
    tick();
    chk("w1000.clr", UART_timer_o, 0);
    UART_we_n_i = 1'b1;
    tick();
    chk("w1000.inc", UART_timer_o, 1);

    force dut.uart_timer_q = 26'd49999989;
    #2 release dut.uart_timer_q;
    #1 chk("to.forced", UART_timer_o, 49999989);
    et = 49999989;
    for (int k = 0; k < 10; k++) begin
      tick();
      et++;
      chk("to.timer", UART_timer_o, et);
      chk("to.state", top_state_o, 2);
      chk("to.pulse", {UART_unload_o, M1_start_o}, 0);
    end
    tick();
    chk("to.fire_state", top_state_o, 3);
    chk("to.fire_pulse", {UART_unload_o, M1_start_o}, 2'b11);
    chk("to.fire_timer", UART_timer_o, 0);
    tick();
    chk("to.after_pulse", {UART_unload_o, M1_start_o}, 0);

    for (int i = 0; i < 8; i++) begin
      rand_bus();
      #1 chk_bus("m1", 3);
      tick();
      chk("m1.state", top_state_o, 3);
      chk("m1.guard", guard_error_o, 0);
    end
    M1_we_n_i       = 1'b0;
    M1_address_i    = 18'd76799;
    M1_write_data_i = 16'($urandom);
    #1 chk_bus("lim", 3);
    tick();
    chk("lim.guard", guard_error_o, 0);
    M1_address_i = 18'd76800;
    #1 chk_bus("over", 3);
    chk("over.we_n", SRAM_we_n_o, GUARD_ON);
    tick();
    chk("over.guard", guard_error_o, GUARD_ON);
    chk("over.state", top_state_o, 3);
    M1_we_n_i = 1'b1;
    M1_done_i = 1'b1;
    tick();
    chk("done.state", top_state_o, 0);
    M1_done_i = 1'b0;
    chk("done.guard", guard_error_o, GUARD_ON);
    rand_bus();
    #1 chk_bus("done.idle", 0);

    enter_uart("rx2", et);
    force dut.uart_timer_q = 26'h3FFFFFF;
    #2 release dut.uart_timer_q;
    tick();
    chk("sat.state", top_state_o, 3);
    chk("sat.pulse", {UART_unload_o, M1_start_o}, 2'b11);
    chk("sat.timer", UART_timer_o, 0);
    tick();
    chk("sat.m1", top_state_o, 3);

    Reset = 1'b1;
    rand_bus();
    tick();
    chk("mrst.state", top_state_o, 0);
    chk("mrst.pulse", {UART_rx_enable_o, UART_unload_o, M1_start_o}, 0);
    chk("mrst.guard", guard_error_o, 0);
    #1 chk_bus("mrst", 0);
    Reset = 1'b0;
    tick();
    chk("mrst.hold", top_state_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
